// File: rtl/id_ex_pkg.sv
// Shared widths, register-zero constant and pipeline register layouts for the ID/EX stage.
package id_ex_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int CTRL_W    = 16;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // Bubble counts loaded on a newly detected hazard (the load cycle is the first bubble).
  localparam logic [1:0] BUBBLES_EX_PRODUCER = 2'd2;
  localparam logic [1:0] BUBBLES_WB_PRODUCER = 2'd1;
  localparam logic [1:0] BUBBLES_LOAD_USE    = 2'd1;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    rdata_a;
    logic [DATA_W-1:0]    rdata_b;
    logic [REG_IDX_W-1:0] wreg;
    logic                 reg_write;
    logic                 mem_read;
    logic [CTRL_W-1:0]    ctrl;
  } ex_regs_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] wreg;
    logic                 reg_write;
  } shadow_t;

endpackage

// File: rtl/id_ex_stage_hazard_cmp.sv
// Two-source register index comparator: flags when a valid, writing, non-r0 producer
// targets either source of a valid ID instruction.
module hazard_cmp
  import id_ex_pkg::*;
(
  input  logic                 p_valid_i,
  input  logic                 p_reg_write_i,
  input  logic [REG_IDX_W-1:0] p_wreg_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  output logic                 match_rs_o,
  output logic                 match_rt_o
);

  logic qual;

  assign qual       = p_valid_i & p_reg_write_i & (p_wreg_i != REG_ZERO) & id_valid_i;
  assign match_rs_o = qual & (p_wreg_i == id_rs_i);
  assign match_rt_o = qual & (p_wreg_i == id_rt_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection, bubble insertion and forwarding selects.
// Define ID_EX_FWD_EN to enable MEM/WB operand forwarding (only load-use then stalls).
module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [DATA_W-1:0]    id_rdata_a,
  input  logic [DATA_W-1:0]    id_rdata_b,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_wreg,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_rdata_a,
  output logic [DATA_W-1:0]    ex_rdata_b,
  output logic [REG_IDX_W-1:0] ex_wreg,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 control_rdata_a,
  output logic                 control_rdata_b,
  output logic                 id_stall
);

  ex_regs_t   ex_q, ex_d;
  shadow_t    wb_q, wb_d;
  logic       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0] cnt_q, cnt_d;

  logic       ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;
  logic       hazard, new_hazard, bubble;
  logic [1:0] hazard_cnt;
  logic       fwd_a_sel, fwd_b_sel;

  hazard_cmp u_cmp_ex (
    .p_valid_i     (ex_q.valid),
    .p_reg_write_i (ex_q.reg_write),
    .p_wreg_i      (ex_q.wreg),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .match_rs_o    (ex_hit_rs),
    .match_rt_o    (ex_hit_rt)
  );

  hazard_cmp u_cmp_wb (
    .p_valid_i     (wb_q.valid),
    .p_reg_write_i (wb_q.reg_write),
    .p_wreg_i      (wb_q.wreg),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .match_rs_o    (wb_hit_rs),
    .match_rt_o    (wb_hit_rt)
  );

`ifdef ID_EX_FWD_EN
  // The shadow match covers a producer that slid past EX while a load-use bubble was inserted.
  assign hazard     = ex_q.mem_read & (ex_hit_rs | ex_hit_rt);
  assign hazard_cnt = BUBBLES_LOAD_USE;
  assign fwd_a_sel  = ex_hit_rs | wb_hit_rs;
  assign fwd_b_sel  = ex_hit_rt | wb_hit_rt;
`else
  assign hazard     = ex_hit_rs | ex_hit_rt | wb_hit_rs | wb_hit_rt;
  assign hazard_cnt = (ex_hit_rs | ex_hit_rt) ? BUBBLES_EX_PRODUCER : BUBBLES_WB_PRODUCER;
  assign fwd_a_sel  = 1'b0;
  assign fwd_b_sel  = 1'b0;
`endif

  // Hazards are only re-evaluated once a running bubble sequence has drained.
  assign new_hazard = (cnt_q == 2'd0) & hazard;
  assign bubble     = (cnt_q != 2'd0) | new_hazard;
  assign id_stall   = stall_in | hazard | (cnt_q != 2'd0);

  always_comb begin
    ex_d    = ex_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wb_d    = '{valid: ex_q.valid, wreg: ex_q.wreg, reg_write: ex_q.reg_write};
      ex_d    = '0;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
      cnt_d   = 2'd0;
    end else if (stall_in) begin
      cnt_d = cnt_q;
    end else if (bubble) begin
      wb_d    = '{valid: ex_q.valid, wreg: ex_q.wreg, reg_write: ex_q.reg_write};
      ex_d    = '0;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
      cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : hazard_cnt - 2'd1;
    end else begin
      wb_d    = '{valid: ex_q.valid, wreg: ex_q.wreg, reg_write: ex_q.reg_write};
      ex_d    = '{valid: id_valid, rdata_a: id_rdata_a, rdata_b: id_rdata_b, wreg: id_wreg,
                  reg_write: id_reg_write, mem_read: id_mem_read, ctrl: id_ctrl};
      fwd_a_d = fwd_a_sel;
      fwd_b_d = fwd_b_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      wb_q    <= '0;
      fwd_a_q <= 1'b0;
      fwd_b_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_rdata_a      = ex_q.rdata_a;
  assign ex_rdata_b      = ex_q.rdata_b;
  assign ex_wreg         = ex_q.wreg;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_mem_read     = ex_q.mem_read;
  assign ex_ctrl         = ex_q.ctrl;
  assign control_rdata_a = fwd_a_q;
  assign control_rdata_b = fwd_b_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations follow the ID_EX_FWD_EN setting.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rdata_a, id_rdata_b;
  logic [4:0]  id_rs, id_rt, id_wreg;
  logic        id_reg_write, id_mem_read;
  logic [15:0] id_ctrl;
  logic        stall_in, flush;
  logic        ex_valid;
  logic [31:0] ex_rdata_a, ex_rdata_b;
  logic [4:0]  ex_wreg;
  logic        ex_reg_write, ex_mem_read;
  logic [15:0] ex_ctrl;
  logic        control_rdata_a, control_rdata_b;
  logic        id_stall;

  int n_vec  = 0;
  int n_miss = 0;

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rdata_a      (id_rdata_a),
    .id_rdata_b      (id_rdata_b),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_wreg         (id_wreg),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_ctrl         (id_ctrl),
    .stall_in        (stall_in),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_rdata_a      (ex_rdata_a),
    .ex_rdata_b      (ex_rdata_b),
    .ex_wreg         (ex_wreg),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_ctrl         (ex_ctrl),
    .control_rdata_a (control_rdata_a),
    .control_rdata_b (control_rdata_b),
    .id_stall        (id_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wreg, input logic rw, input logic mr,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] c);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_wreg      = wreg;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_rdata_a   = a;
    id_rdata_b   = b;
    id_ctrl      = c;
  endtask

  // Clocks through any bubbles (bounded), checks their count, then clocks the load edge.
  task automatic issue(input string tag, input int exp_bub);
    int nb;
    #1;
    nb = 0;
    while (id_stall && nb < 6) begin
      step();
      chk({tag, "_bubble_valid"}, {31'd0, ex_valid}, 32'd0);
      nb++;
    end
    chk({tag, "_bubbles"}, nb, exp_bub);
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    stall_in = 1'b0;
    flush    = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0);
    #2;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_rdata_a", ex_rdata_a, 32'd0);
    chk("rst_ex_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("rst_ctl_a", {31'd0, control_rdata_a}, 32'd0);
    chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
    rst_n = 1'b1;

    // add r3, r1, r2
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0000_00B2, 16'h1234);
    issue("add3", 0);
    chk("add3_valid", {31'd0, ex_valid}, 32'd1);
    chk("add3_rdata_a", ex_rdata_a, 32'hA5A5_0001);
    chk("add3_rdata_b", ex_rdata_b, 32'h0000_00B2);
    chk("add3_wreg", {27'd0, ex_wreg}, 32'd3);
    chk("add3_rw", {31'd0, ex_reg_write}, 32'd1);
    chk("add3_ctrl", {16'd0, ex_ctrl}, 32'h1234);
    chk("add3_ctl_a", {31'd0, control_rdata_a}, 32'd0);

    // sub r4, r3, r1: back-to-back ALU dependency
    set_id(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 32'h0BAD_0003, 32'h0000_0011, 16'h0042);
    issue("sub4", FWD ? 0 : 2);
    chk("sub4_wreg", {27'd0, ex_wreg}, 32'd4);
    chk("sub4_rdata_a", ex_rdata_a, 32'h0BAD_0003);
    chk("sub4_ctl_a", {31'd0, control_rdata_a}, FWD ? 32'd1 : 32'd0);
    chk("sub4_ctl_b", {31'd0, control_rdata_b}, 32'd0);

    // producer writing r0, then a consumer of r0
    set_id(1'b1, 5'd7, 5'd8, 5'd0, 1'b1, 1'b0, 32'h5, 32'h6, 16'h0);
    issue("r0prod", 0);
    chk("r0prod_rw", {31'd0, ex_reg_write}, 32'd1);
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h77, 32'h88, 16'h0);
    issue("r0use", 0);
    chk("r0use_ctl_a", {31'd0, control_rdata_a}, 32'd0);
    chk("r0use_ctl_b", {31'd0, control_rdata_b}, 32'd0);
    chk("r0use_rdata_a", ex_rdata_a, 32'h77);

    // lw r5 then add r6, r5, r5
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'h1000, 32'h0, 16'h00F0);
    issue("lw5", 0);
    chk("lw5_mem_read", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'h2, 32'h3, 16'h0001);
    issue("add6", FWD ? 1 : 2);
    chk("add6_wreg", {27'd0, ex_wreg}, 32'd6);
    chk("add6_ctl_a", {31'd0, control_rdata_a}, FWD ? 32'd1 : 32'd0);
    chk("add6_ctl_b", {31'd0, control_rdata_b}, FWD ? 32'd1 : 32'd0);

    // stall_in held for three cycles in the middle of a bubble sequence
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'h8, 32'h0, 16'h0);
    issue("lw8", 0);
    set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b0, 32'h99, 32'hAA, 16'h3);
    #1;
    chk("use8_id_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk("use8_bubble", {31'd0, ex_valid}, 32'd0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_valid", i), {31'd0, ex_valid}, 32'd0);
      chk($sformatf("stall%0d_wreg", i), {27'd0, ex_wreg}, 32'd0);
      chk($sformatf("stall%0d_id_stall", i), {31'd0, id_stall}, 32'd1);
    end
    stall_in = 1'b0;
    issue("stall_rel", FWD ? 0 : 1);
    chk("use8_wreg", {27'd0, ex_wreg}, 32'd10);
    chk("use8_ctl_a", {31'd0, control_rdata_a}, FWD ? 32'd1 : 32'd0);

    // stall_in freezing a valid EX instruction, then flush during a bubble
    set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'hB, 32'h0, 16'h0);
    issue("lw11", 0);
    stall_in = 1'b1;
    set_id(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0, 32'hC, 32'h0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("hold%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("hold%0d_wreg", i), {27'd0, ex_wreg}, 32'd11);
    end
    stall_in = 1'b0;
    #1;
    chk("use11_id_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk("use11_bubble", {31'd0, ex_valid}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ctl_a", {31'd0, control_rdata_a}, 32'd0);
    #1;
    chk("flush_id_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("use11_valid", {31'd0, ex_valid}, 32'd1);
    chk("use11_wreg", {27'd0, ex_wreg}, 32'd12);
    chk("use11_ctl_a", {31'd0, control_rdata_a}, 32'd0);

    // asynchronous reset between edges with a valid EX instruction
    set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 32'hD, 32'h0, 16'h5);
    issue("lw13", 0);
    set_id(1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 32'hE, 32'hF, 16'h6);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("arst_ctrl", {16'd0, ex_ctrl}, 32'd0);
    chk("arst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("arst_mem_read", {31'd0, ex_mem_read}, 32'd0);
    chk("arst_rdata_a", ex_rdata_a, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("arst_id_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("post_arst_wreg", {27'd0, ex_wreg}, 32'd14);
    chk("post_arst_valid", {31'd0, ex_valid}, 32'd1);

    // reset in the middle of a bubble sequence abandons the stall
    set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 32'h15, 32'h0, 16'h0);
    issue("lw15", 0);
    set_id(1'b1, 5'd15, 5'd15, 5'd16, 1'b1, 1'b0, 32'h16, 32'h17, 16'h7);
    step();
    chk("use15_bubble", {31'd0, ex_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("midbub_id_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("use15_valid", {31'd0, ex_valid}, 32'd1);
    chk("use15_wreg", {27'd0, ex_wreg}, 32'd16);
    chk("use15_ctl_a", {31'd0, control_rdata_a}, 32'd0);
    chk("use15_ctl_b", {31'd0, control_rdata_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
